voice_mixer: RTL and testbench

- Sits between the time-multiplexed sample generator and the PWM audio output stage.
- Consumes the 4-slot sample stream: slot 0 is the cello, slots 1–3 are violins 1–3; the slot index is the low two bits of the music counter.
- Applies a per-voice decay envelope that is retriggered on each note change.
- Sums the four weighted voices and emits one saturated 8-bit unsigned mixed sample per frame for the PWM stage.

---
 rtl/voice_mixer.sv | 116 +++++++++++
 tb/tb_voice_mixer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Four-voice mixer: scales each time-multiplexed voice sample by its decay envelope,
// sums one frame (slots 0..3) and emits a saturated 8-bit unsigned sample per frame.
module voice_mixer #(
    parameter int unsigned SHIFT     = 2,
    parameter int unsigned DECAY_DIV = 256,
    parameter int unsigned SUSTAIN   = 96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  slot,
    input  logic [7:0]  sample_in,
    input  logic [3:0]  note_change,
    output logic [7:0]  mix_sample,
    output logic        mix_valid,
    output logic [31:0] env_level
);

    localparam int unsigned ACC_W  = 10;
    localparam int unsigned PRE_W  = 16;
    localparam int unsigned SUM_W  = 11;
    localparam int unsigned PROD_W = 18;
    localparam int unsigned NVOICE = 4;

    logic [7:0]               env_q [NVOICE];
    logic [7:0]               env_d [NVOICE];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [PRE_W-1:0]         presc_q, presc_d;
    logic [7:0]               mix_q, mix_d;
    logic                     valid_q, valid_d;

    logic signed [8:0]        s_c;
    logic signed [PROD_W-1:0] s_ext_c, env_ext_c, prod_c;
    logic signed [ACC_W-1:0]  term_c, total_c;
    logic signed [SUM_W-1:0]  biased_c;
    logic [7:0]               clamped_c;
    logic                     decay_tick_c;

    // Per-slot voice term and the biased, saturated frame result.
    always_comb begin
        s_c       = $signed({1'b0, sample_in}) - 9'sd128;
        s_ext_c   = PROD_W'(s_c);
        env_ext_c = PROD_W'({1'b0, env_q[slot]});
        prod_c    = s_ext_c * env_ext_c;
        term_c    = ACC_W'(prod_c >>> 8);
        total_c   = acc_q + term_c;
        biased_c  = SUM_W'(total_c >>> SHIFT) + 11'sd128;
        if (biased_c < 11'sd0) begin
            clamped_c = 8'd0;
        end else if (biased_c > 11'sd255) begin
            clamped_c = 8'd255;
        end else begin
            clamped_c = biased_c[7:0];
        end
    end

    // Frame accumulation, output strobe and decay prescaler.
    always_comb begin
        acc_d        = acc_q;
        mix_d        = mix_q;
        valid_d      = 1'b0;
        presc_d      = presc_q;
        decay_tick_c = 1'b0;
        case (slot)
            2'd0: acc_d = term_c;
            2'd1,
            2'd2: acc_d = total_c;
            default: begin
                mix_d   = clamped_c;
                valid_d = 1'b1;
                if (presc_q == PRE_W'(DECAY_DIV - 1)) begin
                    presc_d      = '0;
                    decay_tick_c = 1'b1;
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
        endcase
    end

    // Retrigger beats decay; decay stops at the sustain floor.
    always_comb begin
        for (int v = 0; v < NVOICE; v++) begin
            env_d[v] = env_q[v];
            if (note_change[v]) begin
                env_d[v] = 8'd255;
            end else if (decay_tick_c && (32'(env_q[v]) > SUSTAIN)) begin
                env_d[v] = env_q[v] - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            presc_q <= '0;
            mix_q   <= 8'd128;
            valid_q <= 1'b0;
            for (int v = 0; v < NVOICE; v++) begin
                env_q[v] <= 8'd0;
            end
        end else begin
            acc_q   <= acc_d;
            presc_q <= presc_d;
            mix_q   <= mix_d;
            valid_q <= valid_d;
            for (int v = 0; v < NVOICE; v++) begin
                env_q[v] <= env_d[v];
            end
        end
    end

    assign mix_sample = mix_q;
    assign mix_valid  = valid_q;
    assign env_level  = {env_q[3], env_q[2], env_q[1], env_q[0]};

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: four differently parameterised instances share one stimulus
// stream and are compared every cycle against a frame-level arithmetic model.
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  slot;
    logic [7:0]  sample_in;
    logic [3:0]  note_change;

    logic [7:0]  mix_s [4];
    logic        mv    [4];
    logic [31:0] envl  [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    voice_mixer #(.SHIFT(2), .DECAY_DIV(256), .SUSTAIN(96)) u0 (
        .clk(clk), .rst_n(rst_n), .slot(slot), .sample_in(sample_in), .note_change(note_change),
        .mix_sample(mix_s[0]), .mix_valid(mv[0]), .env_level(envl[0]));
    voice_mixer #(.SHIFT(0), .DECAY_DIV(256), .SUSTAIN(96)) u1 (
        .clk(clk), .rst_n(rst_n), .slot(slot), .sample_in(sample_in), .note_change(note_change),
        .mix_sample(mix_s[1]), .mix_valid(mv[1]), .env_level(envl[1]));
    voice_mixer #(.SHIFT(2), .DECAY_DIV(4), .SUSTAIN(250)) u2 (
        .clk(clk), .rst_n(rst_n), .slot(slot), .sample_in(sample_in), .note_change(note_change),
        .mix_sample(mix_s[2]), .mix_valid(mv[2]), .env_level(envl[2]));
    voice_mixer #(.SHIFT(2), .DECAY_DIV(1), .SUSTAIN(96)) u3 (
        .clk(clk), .rst_n(rst_n), .slot(slot), .sample_in(sample_in), .note_change(note_change),
        .mix_sample(mix_s[3]), .mix_valid(mv[3]), .env_level(envl[3]));

    function automatic int p_shift(int i);
        return (i == 1) ? 0 : 2;
    endfunction
    function automatic int p_div(int i);
        case (i)
            2: return 4;
            3: return 1;
            default: return 256;
        endcase
    endfunction
    function automatic int p_sus(int i);
        return (i == 2) ? 250 : 96;
    endfunction

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int wrap10(int x);
        return ((x + 512) % 1024 + 1024) % 1024 - 512;
    endfunction

    // Reference model state
    int m_env [4][4];
    int m_sum [4];
    int m_frames [4];
    int exp_mix [4];
    bit exp_valid [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 4; v++) m_env[i][v] = 0;
            m_sum[i]     = 0;
            m_frames[i]  = 0;
            exp_mix[i]   = 128;
            exp_valid[i] = 1'b0;
        end
    endtask

    task automatic model_step(int i);
        int term, total, val;
        bit tick;
        int sl;
        sl   = int'(slot);
        term = fdiv((int'(sample_in) - 128) * m_env[i][sl], 256);
        tick = 1'b0;
        exp_valid[i] = 1'b0;
        if (sl == 0) begin
            m_sum[i] = term;
        end else if (sl < 3) begin
            m_sum[i] = wrap10(m_sum[i] + term);
        end else begin
            total = wrap10(m_sum[i] + term);
            val   = fdiv(total, 1 << p_shift(i)) + 128;
            exp_mix[i]   = (val < 0) ? 0 : ((val > 255) ? 255 : val);
            exp_valid[i] = 1'b1;
            m_frames[i]  = m_frames[i] + 1;
            if (m_frames[i] == p_div(i)) begin
                m_frames[i] = 0;
                tick = 1'b1;
            end
        end
        for (int v = 0; v < 4; v++) begin
            if (note_change[v]) m_env[i][v] = 255;
            else if (tick && m_env[i][v] > p_sus(i)) m_env[i][v] = m_env[i][v] - 1;
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int i = 0; i < 4; i++) model_step(i);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = {8'(m_env[i][3]), 8'(m_env[i][2]), 8'(m_env[i][1]), 8'(m_env[i][0])};
            check($sformatf("u%0d.mix_sample", i), 32'(mix_s[i]), 32'(exp_mix[i]));
            check($sformatf("u%0d.mix_valid", i), 32'(mv[i]), 32'(exp_valid[i]));
            check($sformatf("u%0d.env_level", i), envl[i], e);
        end
    end

    task automatic cycle(input logic [1:0] s, input logic [7:0] d, input logic [3:0] nc);
        slot        = s;
        sample_in   = d;
        note_change = nc;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [3:0] nc0);
        cycle(2'd0, d0, nc0);
        cycle(2'd1, d1, 4'b0);
        cycle(2'd2, d2, 4'b0);
        cycle(2'd3, d3, 4'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [1:0] nxt;
        rst_n       = 1'b0;
        slot        = 2'd0;
        sample_in   = 8'd128;
        note_change = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset mix_sample", 32'(mix_s[0]), 32'd128);
        check("reset mix_valid", 32'(mv[0]), 32'd0);
        check("reset env_level", envl[0], 32'd0);
        rst_n = 1'b1;

        // Silence: midpoint output, strobe once per frame
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(2'(k % 4), 8'd128, 4'b0);
            if (mv[0]) pulses++;
        end
        check("silence pulses", 32'(pulses), 32'd3);
        check("silence mix", 32'(mix_s[0]), 32'd128);

        // Single cello voice at full envelope
        frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b0001);
        frame(8'd255, 8'd128, 8'd128, 8'd128, 4'b0000);
        check("cello only mix", 32'(mix_s[0]), 32'd159);
        check("cello only valid", 32'(mv[0]), 32'd1);

        // Full-scale positive and negative, SHIFT=2 and SHIFT=0
        frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b1111);
        frame(8'd255, 8'd255, 8'd255, 8'd255, 4'b0000);
        check("all max shift2", 32'(mix_s[0]), 32'd254);
        check("all max shift0 clamp", 32'(mix_s[1]), 32'd255);
        frame(8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
        check("all min shift2", 32'(mix_s[0]), 32'd0);
        check("all min shift0 clamp", 32'(mix_s[1]), 32'd0);

        // Asynchronous reset forces outputs without a clock edge
        rst_n = 1'b0;
        #1;
        check("async reset mix", 32'(mix_s[0]), 32'd128);
        check("async reset valid", 32'(mv[0]), 32'd0);
        check("async reset env", envl[0], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decay to sustain floor on the DECAY_DIV=4 / SUSTAIN=250 instance
        frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b0100);
        repeat (3) frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b0000);
        check("env2 after 4 frames", 32'(envl[2][23:16]), 32'd254);
        repeat (16) frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b0000);
        check("env2 after 20 frames", 32'(envl[2][23:16]), 32'd250);
        repeat (100) frame(8'd128, 8'd128, 8'd128, 8'd128, 4'b0000);
        check("env2 held at sustain", 32'(envl[2][23:16]), 32'd250);
        check("env0 untouched", 32'(envl[2][7:0]), 32'd0);

        // Retrigger wins over a coincident decay tick; slot-0 restarts a frame
        do_reset();
        cycle(2'd0, 8'd128, 4'b0);
        cycle(2'd1, 8'd128, 4'b0);
        cycle(2'd2, 8'd128, 4'b0);
        cycle(2'd3, 8'd128, 4'b0011);
        check("retrigger beats tick", 32'(envl[3][15:0]), 32'h0000FFFF);
        pulses = 0;
        cycle(2'd0, 8'd0, 4'b0);
        if (mv[3]) pulses++;
        cycle(2'd0, 8'd128, 4'b0);
        if (mv[3]) pulses++;
        cycle(2'd1, 8'd128, 4'b0);
        if (mv[3]) pulses++;
        cycle(2'd2, 8'd128, 4'b0);
        if (mv[3]) pulses++;
        cycle(2'd3, 8'd128, 4'b0);
        if (mv[3]) pulses++;
        check("restart single pulse", 32'(pulses), 32'd1);
        check("restart discards first slot0", 32'(mix_s[3]), 32'd128);

        // Randomised traffic, mostly in-order slots with occasional disorder
        nxt = 2'd0;
        for (int k = 0; k < 4000; k++) begin
            logic [1:0] s;
            logic [3:0] nc;
            s  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : nxt;
            nc = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            cycle(s, 8'($urandom_range(0, 255)), nc);
            nxt = s + 2'd1;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                nxt = 2'd0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
